// File: rtl/simon_pkg.sv
// Shared FSM state encoding, mode indicator constants and sizing helper
// for the Simon sequencer.
package simon_pkg;

    localparam logic [2:0] MODE_INPUT    = 3'b001;
    localparam logic [2:0] MODE_PLAYBACK = 3'b010;
    localparam logic [2:0] MODE_REPEAT   = 3'b100;
    localparam logic [2:0] MODE_DONE     = 3'b111;
    localparam logic [2:0] MODE_WIN      = 3'b101;

    typedef enum logic [2:0] {
        ST_INPUT    = MODE_INPUT,
        ST_PLAYBACK = MODE_PLAYBACK,
        ST_REPEAT   = MODE_REPEAT,
        ST_DONE     = MODE_DONE,
        ST_WIN      = MODE_WIN
    } state_t;

    // Bits needed to hold values 0..n-1, never less than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic logic [2:0] mode_of(input state_t s);
        logic [2:0] m;
        case (s)
            ST_INPUT:    m = MODE_INPUT;
            ST_PLAYBACK: m = MODE_PLAYBACK;
            ST_REPEAT:   m = MODE_REPEAT;
            ST_DONE:     m = MODE_DONE;
            ST_WIN:      m = MODE_WIN;
            default:     m = MODE_INPUT;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/simon_sequencer_if.sv
// Player-facing bus of the Simon sequencer: switch submit and display outputs.
interface simon_sequencer_if #(
    parameter int NUM_LEDS  = 4,
    parameter int MAX_DEPTH = 16
);
    localparam int LW = $clog2(MAX_DEPTH + 1);

    logic [NUM_LEDS-1:0] pattern_in;
    logic                pattern_valid;
    logic [NUM_LEDS-1:0] pattern_leds;
    logic [2:0]          mode_leds;
    logic [LW-1:0]       level;

    modport master (
        output pattern_in, pattern_valid,
        input  pattern_leds, mode_leds, level
    );

    modport slave (
        input  pattern_in, pattern_valid,
        output pattern_leds, mode_leds, level
    );

endinterface

// File: rtl/simon_pattern_mem.sv
// Pattern storage: one synchronous write port, one asynchronous read port.
module simon_pattern_mem #(
    parameter int NUM_LEDS  = 4,
    parameter int MAX_DEPTH = 16,
    parameter int AW        = 4
) (
    input  logic                clk,
    input  logic                wr_en,
    input  logic [AW-1:0]       wr_addr,
    input  logic [NUM_LEDS-1:0] wr_data,
    input  logic [AW-1:0]       rd_addr,
    output logic [NUM_LEDS-1:0] rd_data
);

    logic [NUM_LEDS-1:0] mem [MAX_DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/simon_sequencer.sv
// Simon memory game sequencer: record, play back, check repeats, then end
// in a replaying DONE state or an all-on WIN state.
module simon_sequencer
    import simon_pkg::*;
#(
    parameter int NUM_LEDS   = 4,
    parameter int MAX_DEPTH  = 16,
    parameter int PLAY_TICKS = 4,
    parameter int TIMEOUT    = 0
) (
    input logic              clk,
    input logic              rst,
    simon_sequencer_if.slave bus
);

    localparam int LW      = $clog2(MAX_DEPTH + 1);
    localparam int IW      = idx_width(MAX_DEPTH);
    localparam int TW      = idx_width(PLAY_TICKS);
    localparam int OW      = idx_width(TIMEOUT);
    localparam int TO_LAST = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

    state_t              state;
    logic [LW-1:0]       level;
    logic [IW-1:0]       play_idx;
    logic [IW-1:0]       rep_idx;
    logic [TW-1:0]       tick;
    logic [OW-1:0]       to_cnt;
    logic [NUM_LEDS-1:0] rd_data;
    logic [IW-1:0]       rd_addr;
    logic                wr_en;
    logic                legal;
    logic                tick_done;
    logic                last_play;
    logic                last_rep;
    logic                match;
    logic                timed_out;

    assign legal     = $onehot(bus.pattern_in);
    assign wr_en     = (state == ST_INPUT) && bus.pattern_valid && legal;
    assign tick_done = (tick == TW'(PLAY_TICKS - 1));
    assign last_play = (LW'(play_idx) == level - LW'(1));
    assign last_rep  = (LW'(rep_idx) == level - LW'(1));
    assign match     = (bus.pattern_in == rd_data);
    assign timed_out = (TIMEOUT > 0) && (to_cnt == OW'(TO_LAST));
    assign rd_addr   = (state == ST_REPEAT) ? rep_idx : play_idx;

    simon_pattern_mem #(
        .NUM_LEDS (NUM_LEDS),
        .MAX_DEPTH(MAX_DEPTH),
        .AW       (IW)
    ) u_mem (
        .clk    (clk),
        .wr_en  (wr_en),
        .wr_addr(level[IW-1:0]),
        .wr_data(bus.pattern_in),
        .rd_addr(rd_addr),
        .rd_data(rd_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_INPUT;
            level    <= '0;
            play_idx <= '0;
            rep_idx  <= '0;
            tick     <= '0;
            to_cnt   <= '0;
        end else begin
            case (state)
                ST_INPUT: begin
                    if (wr_en) begin
                        level    <= level + LW'(1);
                        play_idx <= '0;
                        tick     <= '0;
                        state    <= ST_PLAYBACK;
                    end
                end
                // DONE reuses the playback walk but wraps instead of leaving.
                ST_PLAYBACK, ST_DONE: begin
                    if (tick_done) begin
                        tick <= '0;
                        if (last_play) begin
                            play_idx <= '0;
                            if (state == ST_PLAYBACK) begin
                                state   <= ST_REPEAT;
                                rep_idx <= '0;
                                to_cnt  <= '0;
                            end
                        end else begin
                            play_idx <= play_idx + IW'(1);
                        end
                    end else begin
                        tick <= tick + TW'(1);
                    end
                end
                ST_REPEAT: begin
                    if (bus.pattern_valid) begin
                        if (!match) begin
                            state    <= ST_DONE;
                            play_idx <= '0;
                            tick     <= '0;
                        end else if (last_rep) begin
                            state <= (level == LW'(MAX_DEPTH)) ? ST_WIN : ST_INPUT;
                        end else begin
                            rep_idx <= rep_idx + IW'(1);
                            to_cnt  <= '0;
                        end
                    end else if (timed_out) begin
                        state    <= ST_DONE;
                        play_idx <= '0;
                        tick     <= '0;
                    end else if (TIMEOUT > 0) begin
                        to_cnt <= to_cnt + OW'(1);
                    end
                end
                ST_WIN: begin
                    state <= ST_WIN;
                end
                default: begin
                    state <= ST_INPUT;
                end
            endcase
        end
    end

    always_comb begin
        bus.pattern_leds = bus.pattern_in;
        case (state)
            ST_PLAYBACK, ST_DONE: bus.pattern_leds = rd_data;
            ST_WIN:               bus.pattern_leds = '1;
            default:              bus.pattern_leds = bus.pattern_in;
        endcase
    end

    assign bus.mode_leds = mode_of(state);
    assign bus.level     = level;

endmodule
